// File: rtl/snow64_bfloat16_vector_add_seq_pkg.sv
// Shared types and constants for the BFloat16 vector add sequencer.
package snow64_bfloat16_vector_add_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_vec_add_seq_t;

    localparam int NUM_VEC_LANES  = 4;
    localparam int WIDTH_VEC_LANE = 16;
    localparam int WIDTH_VEC      = NUM_VEC_LANES * WIDTH_VEC_LANE;
    localparam int WIDTH_LANE_IDX = 2;

    localparam logic [WIDTH_LANE_IDX-1:0] LAST_LANE = WIDTH_LANE_IDX'(NUM_VEC_LANES - 1);

    // Extract one 16-bit lane from a packed vector.
    function automatic logic [WIDTH_VEC_LANE-1:0] get_lane(
        input logic [WIDTH_VEC-1:0]      vec,
        input logic [WIDTH_LANE_IDX-1:0] idx
    );
        return vec[idx * WIDTH_VEC_LANE +: WIDTH_VEC_LANE];
    endfunction

endpackage

// File: rtl/snow64_bfloat16_vector_add_seq.sv
// Sequencer that feeds four BFloat16 lane pairs through one shared add unit
// and assembles the 64-bit result vector.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for in_start; unit_data_valid ignored
// ST_ISSUE | presenting lane operands, strobing unit_start when unit is idle
// ST_WAIT  | operands held, waiting for unit_data_valid to capture the lane
// ST_DONE  | one-cycle out_done pulse, then back to idle
module snow64_bfloat16_vector_add_seq
    import snow64_bfloat16_vector_add_seq_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_start,
    input  logic                      in_op,
    input  logic [WIDTH_VEC-1:0]      in_a,
    input  logic [WIDTH_VEC-1:0]      in_b,
    output logic                      out_busy,
    output logic                      out_done,
    output logic [WIDTH_VEC-1:0]      out_data,
    output logic                      unit_start,
    output logic [WIDTH_VEC_LANE-1:0] unit_a,
    output logic [WIDTH_VEC_LANE-1:0] unit_b,
    input  logic                      unit_data_valid,
    input  logic                      unit_can_accept_cmd,
    input  logic [WIDTH_VEC_LANE-1:0] unit_data
);

    state_vec_add_seq_t          state;
    state_vec_add_seq_t          next_state;
    logic [WIDTH_LANE_IDX-1:0]   lane;
    logic [WIDTH_VEC-1:0]        a_reg;
    logic [WIDTH_VEC-1:0]        b_reg;
    logic                        op_reg;
    logic                        accept;
    logic                        write_lane;

    // Subtraction is realised purely by flipping the sign of operand b.
    assign unit_a = get_lane(a_reg, lane);
    assign unit_b = get_lane(b_reg, lane) ^ {op_reg, {(WIDTH_VEC_LANE-1){1'b0}}};

    // Next-state decode plus the combinational start strobe.
    always_comb begin
        next_state = state;
        unit_start = 1'b0;
        accept     = 1'b0;
        write_lane = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_start) begin
                    accept     = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (unit_can_accept_cmd) begin
                    unit_start = 1'b1;
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (unit_data_valid) begin
                    write_lane = 1'b1;
                    next_state = (lane == LAST_LANE) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State, operand capture, lane counter and result assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            lane     <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= 1'b0;
            out_busy <= 1'b0;
            out_done <= 1'b0;
            out_data <= '0;
        end else begin
            state    <= next_state;
            out_busy <= (next_state != ST_IDLE);
            out_done <= (next_state == ST_DONE);
            if (accept) begin
                a_reg  <= in_a;
                b_reg  <= in_b;
                op_reg <= in_op;
                lane   <= '0;
            end
            if (write_lane) begin
                out_data[lane * WIDTH_VEC_LANE +: WIDTH_VEC_LANE] <= unit_data;
                // Lane stays at the last index through Done; only a new
                // command brings it back to zero.
                if (lane != LAST_LANE) begin
                    lane <= lane + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_snow64_bfloat16_vector_add_seq.sv
// Bench for the BFloat16 vector add sequencer with a behavioural add-unit stub.
module tb_snow64_bfloat16_vector_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_start;
    logic        in_op;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        out_busy;
    logic        out_done;
    logic [63:0] out_data;
    logic        unit_start;
    logic [15:0] unit_a;
    logic [15:0] unit_b;
    logic        unit_data_valid;
    logic        unit_can_accept_cmd;
    logic [15:0] unit_data;

    int n_vec = 0;
    int n_bad = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    snow64_bfloat16_vector_add_seq dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_start            (in_start),
        .in_op               (in_op),
        .in_a                (in_a),
        .in_b                (in_b),
        .out_busy            (out_busy),
        .out_done            (out_done),
        .out_data            (out_data),
        .unit_start          (unit_start),
        .unit_a              (unit_a),
        .unit_b              (unit_b),
        .unit_data_valid     (unit_data_valid),
        .unit_can_accept_cmd (unit_can_accept_cmd),
        .unit_data           (unit_data)
    );

    // ---------------- reference arithmetic (bf16 via real) ----------------
    function automatic real bf2r(input logic [15:0] x);
        real p;
        int  e;
        e = int'(x[14:7]);
        if (e == 0) return 0.0;
        p = 1.0 + real'(int'(x[6:0])) / 128.0;
        if (e > 127) repeat (e - 127) p = p * 2.0;
        else         repeat (127 - e) p = p / 2.0;
        return x[15] ? -p : p;
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        real mag;
        int  e;
        int  m;
        logic s;
        if (r == 0.0) return 16'h0000;
        s   = (r < 0.0);
        mag = s ? -r : r;
        e   = 127;
        while (mag >= 2.0) begin mag = mag / 2.0; e++; end
        while (mag < 1.0)  begin mag = mag * 2.0; e--; end
        if (e <= 0)   return {s, 15'h0};
        if (e >= 255) return {s, 8'hFF, 7'h0};
        m = $rtoi((mag - 1.0) * 128.0);
        return {s, e[7:0], m[6:0]};
    endfunction

    function automatic logic [15:0] bf16_add(input logic [15:0] x, input logic [15:0] y);
        return r2bf(bf2r(x) + bf2r(y));
    endfunction

    // ---------------- add-unit stub: valid visible 3 cycles after start ----
    logic [1:0]  stub_cnt   = 2'd0;
    logic        stub_valid = 1'b0;
    logic [15:0] stub_data  = 16'h0;
    logic        stall      = 1'b0;

    assign unit_can_accept_cmd = (stub_cnt == 2'd0) && !stall;
    assign unit_data_valid     = stub_valid;
    assign unit_data           = stub_data;

    // Stub unit: clears valid on the start-sampling edge, never reset.
    always @(posedge clk) begin
        if (unit_start && unit_can_accept_cmd) begin
            stub_valid <= 1'b0;
            stub_cnt   <= 2'd2;
            stub_data  <= bf16_add(unit_a, unit_b);
        end else if (stub_cnt != 2'd0) begin
            stub_cnt <= stub_cnt - 2'd1;
            if (stub_cnt == 2'd1) stub_valid <= 1'b1;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_vec(input logic op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        for (int i = 0; i < 4; i++)
            r[i*16 +: 16] = bf16_add(a[i*16 +: 16], b[i*16 +: 16] ^ {op, 15'h0});
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  {63'h0, out_busy},   64'h0);
        chk({tag, "_done"},  {63'h0, out_done},   64'h0);
        chk({tag, "_data"},  out_data,            64'h0);
        chk({tag, "_start"}, {63'h0, unit_start}, 64'h0);
        chk({tag, "_ua"},    {48'h0, unit_a},     64'h0);
        chk({tag, "_ub"},    {48'h0, unit_b},     64'h0);
    endtask

    // Runs one command from the current cycle (cycle 0 = in_start driven).
    task automatic run_cmd(input string tag, input logic op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp,
                           input int exp_done, input int stall_from,
                           input int stall_len, input bit inject);
        int starts;
        int done_cyc;
        int cyc;
        int extra_done;
        logic [15:0] lb;
        starts   = 0;
        done_cyc = -1;
        cyc      = 0;
        in_a = a; in_b = b; in_op = op; in_start = 1'b1;
        while (done_cyc < 0 && cyc < 200) begin
            tick();
            cyc++;
            if (cyc == 1) in_start = 1'b0;
            if (inject && cyc == 5) begin
                in_start = 1'b1; in_a = ~a; in_b = ~b; in_op = ~op;
            end
            if (inject && cyc == 6) begin
                in_start = 1'b0; in_a = a; in_b = b; in_op = op;
            end
            stall = (cyc >= stall_from) && (cyc < stall_from + stall_len);
            #1;
            if (cyc == 1) chk({tag, "_busy_c1"}, {63'h0, out_busy}, 64'h1);
            if (stall) begin
                lb = b[starts*16 +: 16] ^ {op, 15'h0};
                chk({tag, "_stall_nostart"}, {63'h0, unit_start}, 64'h0);
                chk({tag, "_stall_ua"}, {48'h0, unit_a}, {48'h0, a[starts*16 +: 16]});
                chk({tag, "_stall_ub"}, {48'h0, unit_b}, {48'h0, lb});
            end
            if (unit_start) begin
                if (starts < 4) begin
                    lb = b[starts*16 +: 16] ^ {op, 15'h0};
                    chk({tag, "_ua"}, {48'h0, unit_a}, {48'h0, a[starts*16 +: 16]});
                    chk({tag, "_ub"}, {48'h0, unit_b}, {48'h0, lb});
                end
                starts++;
            end
            if (out_done) done_cyc = cyc;
        end
        stall = 1'b0;
        chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_starts"}, 64'(starts), 64'd4);
        tick();
        chk({tag, "_idle_busy"}, {63'h0, out_busy}, 64'h0);
        chk({tag, "_idle_done"}, {63'h0, out_done}, 64'h0);
        if (inject) begin
            extra_done = 0;
            repeat (25) begin
                tick();
                if (out_done || out_busy) extra_done++;
            end
            chk({tag, "_no_second_cmd"}, 64'(extra_done), 64'h0);
            chk({tag, "_data_held"}, out_data, exp);
        end
    endtask

    typedef struct {
        logic        op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          exp_done;
        int          stall_from;
        int          stall_len;
        bit          inject;
    } vec_t;

    vec_t tbl[5];

    function automatic logic [15:0] rand_lane();
        logic [7:0] e;
        logic [6:0] m;
        logic       s;
        s = 1'($urandom_range(1, 0));
        e = 8'($urandom_range(140, 110));
        m = 7'($urandom_range(127, 0));
        return {s, e, m};
    endfunction

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rop;

        tbl[0] = '{1'b0, 64'h4000_3F80_3F00_3F80, 64'h3F80_3F80_3F00_3F80,
                   64'h4040_4000_3F80_4000, 17, 0, 0, 1'b0};
        tbl[1] = '{1'b1, 64'h4040_4040_4040_4040, 64'h3F80_3F80_3F80_3F80,
                   64'h4000_4000_4000_4000, 17, 0, 0, 1'b0};
        tbl[2] = '{1'b1, 64'h3F80_3F80_3F80_3F80, 64'h3F80_3F80_3F80_3F80,
                   64'h0000_0000_0000_0000, 17, 0, 0, 1'b0};
        tbl[3] = '{1'b0, 64'h3F80_4000_4040_4080, 64'h3F80_3F80_3F80_3F80,
                   64'h4000_4040_4080_40A0, 22, 9, 5, 1'b0};
        tbl[4] = '{1'b0, 64'h4040_4040_4040_4040, 64'h4000_4000_4000_4000,
                   64'h40A0_40A0_40A0_40A0, 17, 0, 0, 1'b1};

        rst = 1'b1; in_start = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++)
            run_cmd($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp,
                    tbl[i].exp_done, tbl[i].stall_from, tbl[i].stall_len, tbl[i].inject);

        // Reset in cycle 6 of a command; the stub's lane-1 valid lands in cycle 8.
        in_a = 64'h4000_4000_4000_4000; in_b = 64'h3F80_3F80_3F80_3F80;
        in_op = 1'b0; in_start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) in_start = 1'b0;
            if (c == 6) rst = 1'b1;
            if (c == 7) rst = 1'b0;
            if (c >= 7) chk_all_zero($sformatf("midrst_c%0d", c));
        end
        tick();
        run_cmd("after_rst", 1'b0, 64'h3F80_3F00_4000_4040, 64'h3F80_3F00_3F80_3F80,
                64'h4000_3F80_4040_4080, 17, 0, 0, 1'b0);

        // Reset and start in the same cycle: the start is dropped.
        rst = 1'b1; in_start = 1'b1;
        tick();
        rst = 1'b0; in_start = 1'b0;
        chk("rst_start_busy0", {63'h0, out_busy}, 64'h0);
        tick();
        chk("rst_start_busy1", {63'h0, out_busy}, 64'h0);
        chk("rst_start_nostart", {63'h0, unit_start}, 64'h0);

        // Randomised commands against the real-arithmetic reference.
        for (int k = 0; k < 8; k++) begin
            for (int l = 0; l < 4; l++) begin
                ra[l*16 +: 16] = rand_lane();
                rb[l*16 +: 16] = rand_lane();
            end
            rop = 1'($urandom_range(1, 0));
            run_cmd($sformatf("rand%0d", k), rop, ra, rb, model_vec(rop, ra, rb), 17, 0, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
